fft_sample_reader: RTL and testbench

FFT_SAMPLE_READER -- requirements
Module: fft_sample_reader

---
 rtl/fft_mem_pkg.sv | 21 ++
 rtl/fft_stream_fifo.sv | 62 ++++++
 rtl/fft_sample_reader.sv | 155 +++++++++++++++
 tb/tb_fft_sample_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_mem_pkg.sv
// Shared widths and the reader state encoding for the FFT sample memory path.
package fft_mem_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int WADDR_W_DEF = 11;
    localparam int BYTE_OFS_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Byte address for a 64-bit word address; the low offset bits are always zero.
    function automatic logic [WADDR_W_DEF+BYTE_OFS_W-1:0] word_to_byte(
        input logic [WADDR_W_DEF-1:0] waddr
    );
        return {waddr, {BYTE_OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fft_stream_fifo.sv
// Small synchronous FIFO buffering read data ahead of the output stream.
module fft_stream_fifo #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr_en && (count_q != CNT_W'(DEPTH));
    assign do_rd = rd_en && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates everything that reads it.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;

endmodule

// File: rtl/fft_sample_reader.sv
// Reads a run of words over Avalon-MM and streams them out, with read credits
// bounded by the output FIFO so returning data always has somewhere to land.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ISSUE | issuing reads while credits allow
// ST_DRAIN | all reads issued, delivering the remaining words
module fft_sample_reader
    import fft_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int WADDR_W    = WADDR_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [WADDR_W-1:0]      cmd_base,
    input  logic [WADDR_W:0]        cmd_len,
    output logic [WADDR_W+2:0]      avm_address,
    output logic                    avm_read,
    output logic [DATA_W/8-1:0]     avm_byteenable,
    input  logic                    avm_waitrequest,
    input  logic                    avm_readdatavalid,
    input  logic [DATA_W-1:0]       avm_readdata,
    output logic [DATA_W-1:0]       src_data,
    output logic                    src_valid,
    input  logic                    src_ready,
    output logic                    src_last,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LEN_W = WADDR_W + 1;

    rd_state_e          state_q, state_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]   issue_left_q, issue_left_d;
    logic [LEN_W-1:0]   deliver_left_q, deliver_left_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_wr;
    logic               fifo_rd;
    logic               fifo_out_valid;
    logic [DATA_W-1:0]  fifo_out_data;
    logic [CNT_W:0]     credit_used;
    logic               credit_ok;
    logic               rd_issue;
    logic               last_word;

    // Credits cover both in-flight reads and words parked in the FIFO.
    assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

    assign avm_read       = (state_q == ST_ISSUE) && credit_ok;
    assign rd_issue       = avm_read && !avm_waitrequest;
    assign avm_address    = {addr_q, {BYTE_OFS_W{1'b0}}};
    assign avm_byteenable = '1;

    assign fifo_wr   = avm_readdatavalid && (state_q != ST_IDLE);
    assign fifo_rd   = fifo_out_valid && src_ready;
    assign last_word = (deliver_left_q == LEN_W'(1));

    assign src_valid = fifo_out_valid;
    assign src_data  = fifo_out_data;
    assign src_last  = fifo_out_valid && last_word;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    fft_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (fifo_wr),
        .wr_data  (avm_readdata),
        .rd_en    (fifo_rd),
        .rd_data  (fifo_out_data),
        .rd_valid (fifo_out_valid),
        .count    (fifo_count)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        outst_d        = outst_q + CNT_W'(rd_issue) - CNT_W'(fifo_wr);
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d         = cmd_base;
                        issue_left_d   = cmd_len;
                        deliver_left_d = cmd_len;
                        state_d        = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (rd_issue) begin
                    addr_d       = addr_q + WADDR_W'(1);
                    issue_left_d = issue_left_q - LEN_W'(1);
                    if (issue_left_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Delivery accounting runs in both active states.
        if ((state_q != ST_IDLE) && fifo_rd) begin
            deliver_left_d = deliver_left_q - LEN_W'(1);
            if (last_word) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            outst_q        <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
            outst_q        <= outst_d;
            done_q         <= done_d;
        end
    end

endmodule

// File: tb/tb_fft_sample_reader.sv
// Directed bench for fft_sample_reader: Avalon slave model plus a scoreboard
// of expected read addresses and output words checked by monitor processes.
module tb_fft_sample_reader;

    localparam int DW    = 64;
    localparam int AW    = 11;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_base;
    logic [AW:0]     cmd_len;
    logic [AW+2:0]   avm_address;
    logic            avm_read;
    logic [DW/8-1:0] avm_byteenable;
    logic            avm_waitrequest;
    logic            avm_readdatavalid;
    logic [DW-1:0]   avm_readdata;
    logic [DW-1:0]   src_data;
    logic            src_valid;
    logic            src_ready;
    logic            src_last;
    logic            busy;
    logic            done;

    fft_sample_reader #(
        .DATA_W     (DW),
        .WADDR_W    (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_base          (cmd_base),
        .cmd_len           (cmd_len),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_last          (src_last),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [AW+2:0] exp_addr_q [$];
    logic [DW:0]   exp_word_q [$];

    bit            pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int            reads_acc = 0;
    int            pop_cnt   = 0;
    int            done_cnt  = 0;
    int            stall_idx  = -1;
    int            stall_left = 0;
    logic [DW:0]   mon_w;
    logic [AW+2:0] slv_a;

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 64'hC0DE_0000_0000_0000 | {32'h0, 5'h0, a, 5'h0, a};
    endfunction

    // Avalon slave: fixed one-cycle read latency, optional waitrequest stall.
    always @(negedge clk) begin
        avm_readdatavalid = pend;
        avm_readdata      = pend ? mem_word(pend_addr) : '0;
        if (avm_read && reads_acc == stall_idx && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
            check("stall_addr_hold", 65'(avm_address), 65'h8);
        end else begin
            avm_waitrequest = 1'b0;
        end
        pend = avm_read && !avm_waitrequest && !reset;
        if (pend) begin
            pend_addr = avm_address[AW+2:3];
            reads_acc++;
            if (exp_addr_q.size() == 0) begin
                check("unexpected_read", 65'(avm_address), 65'h1_FFFF_FFFF_FFFF_FFFF);
            end else begin
                slv_a = exp_addr_q.pop_front();
                check("rd_addr", 65'(avm_address), 65'(slv_a));
            end
            check("credit_limit", 65'((reads_acc - pop_cnt) <= DEPTH), 65'd1);
        end
    end

    // Output monitor: one scoreboard entry per accepted output word.
    always @(negedge clk) begin
        if (!reset && src_valid && src_ready) begin
            pop_cnt++;
            if (exp_word_q.size() == 0) begin
                check("unexpected_word", {src_last, src_data}, 65'h1_FFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_w = exp_word_q.pop_front();
                check("src_data", 65'(src_data), 65'(mon_w[DW-1:0]));
                check("src_last", 65'(src_last), 65'(mon_w[DW]));
            end
        end
        if (done) done_cnt++;
    end

    task automatic expect_words(input int base, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = AW'((base + i) % 2048);
            exp_addr_q.push_back({a, 3'b000});
            exp_word_q.push_back({(i == len - 1), mem_word(a)});
        end
    endtask

    task automatic send_cmd(input int base, input int len);
        @(negedge clk);
        check("cmd_ready_idle", 65'(cmd_ready), 65'd1);
        cmd_valid = 1'b1;
        cmd_base  = AW'(base);
        cmd_len   = (AW+1)'(len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 65'(done), 65'd1);
    endtask

    task automatic clear_counts();
        reads_acc = 0;
        pop_cnt   = 0;
    endtask

    task automatic run_cmd(input string tag, input int base, input int len);
        int d0;
        clear_counts();
        d0 = done_cnt;
        expect_words(base, len);
        send_cmd(base, len);
        wait_done(300);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 65'(done_cnt - d0), 65'd1);
        check({tag, "_words"}, 65'(pop_cnt), 65'(len));
        check({tag, "_reads"}, 65'(reads_acc), 65'(len));
        check({tag, "_sb_empty"}, 65'(exp_word_q.size() + exp_addr_q.size()), 65'd0);
        check({tag, "_busy_low"}, 65'(busy), 65'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_base        = '0;
        cmd_len         = '0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata    = '0;
        src_ready       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 65'(cmd_ready), 65'd1);
        check("rst_avm_read", 65'(avm_read), 65'd0);
        check("rst_avm_address", 65'(avm_address), 65'd0);
        check("rst_src_valid", 65'(src_valid), 65'd0);
        check("rst_src_last", 65'(src_last), 65'd0);
        check("rst_busy", 65'(busy), 65'd0);
        check("rst_done", 65'(done), 65'd0);
        check("byteenable", 65'(avm_byteenable), 65'hFF);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic four-word read from address 0.
        run_cmd("basic", 0, 4);

        // Word address wraps 2047 -> 0.
        run_cmd("wrap", 2046, 4);

        // Backpressure: credits must cap in-flight reads at the FIFO depth.
        src_ready = 1'b0;
        clear_counts();
        d0 = done_cnt;
        expect_words(100, 8);
        send_cmd(100, 8);
        repeat (20) @(negedge clk);
        check("bp_reads_capped", 65'(reads_acc), 65'd4);
        check("bp_head_valid", 65'(src_valid), 65'd1);
        check("bp_head_data", 65'(src_data), 65'(mem_word(11'd100)));
        check("bp_busy", 65'(busy), 65'd1);
        src_ready = 1'b1;
        wait_done(300);
        repeat (3) @(negedge clk);
        check("bp_done_once", 65'(done_cnt - d0), 65'd1);
        check("bp_words", 65'(pop_cnt), 65'd8);
        check("bp_sb_empty", 65'(exp_word_q.size() + exp_addr_q.size()), 65'd0);

        // Waitrequest held three cycles on the second read.
        stall_idx  = 1;
        stall_left = 3;
        run_cmd("stall", 0, 4);
        check("stall_consumed", 65'(stall_left), 65'd0);
        stall_idx = -1;

        // Zero-length command: done next cycle, no reads, never busy.
        clear_counts();
        d0 = done_cnt;
        send_cmd(5, 0);
        @(negedge clk);
        check("len0_done_pulse", 65'(done), 65'd1);
        check("len0_busy", 65'(busy), 65'd0);
        @(negedge clk);
        check("len0_done_low", 65'(done), 65'd0);
        repeat (3) @(negedge clk);
        check("len0_no_reads", 65'(reads_acc), 65'd0);
        check("len0_done_once", 65'(done_cnt - d0), 65'd1);

        // Reset after two of six words have been delivered.
        clear_counts();
        d0 = done_cnt;
        expect_words(300, 6);
        send_cmd(300, 6);
        n = 0;
        while (pop_cnt < 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("mid_two_popped", 65'(pop_cnt), 65'd2);
        #1;
        reset     = 1'b1;
        src_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_cmd_ready", 65'(cmd_ready), 65'd1);
        check("mid_avm_read", 65'(avm_read), 65'd0);
        check("mid_avm_address", 65'(avm_address), 65'd0);
        check("mid_src_valid", 65'(src_valid), 65'd0);
        check("mid_src_last", 65'(src_last), 65'd0);
        check("mid_busy", 65'(busy), 65'd0);
        check("mid_done", 65'(done), 65'd0);
        reset = 1'b0;
        exp_addr_q.delete();
        exp_word_q.delete();
        repeat (5) @(negedge clk);
        check("mid_no_done", 65'(done_cnt - d0), 65'd0);
        check("mid_fifo_dropped", 65'(src_valid), 65'd0);
        src_ready = 1'b1;
        run_cmd("after_rst", 7, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
